circuit_sweep_checker: RTL and testbench

- Sequential self-checking driver for the 3-input/2-output logic circuit family, where d = (a & b) | ~c and e = ~c.
- On start, it drives all eight {a,b,c} vectors in ascending order onto the circuit inputs. After a settle delay it samples the circuit's {d,e}, compares against the expected function, and counts mismatches.
- It sits on the opposite side of the circuit interface from the circuit: it produces abc and consumes de. It replaces the hand-written stimulus/monitor loop with a synthesizable checker.

---
 rtl/circuit_sweep_checker.sv | 145 ++++++++++++++
 tb/tb_circuit_sweep_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/circuit_sweep_checker.sv
// circuit_sweep_checker: synthesizable stimulus/monitor for the 3-in/2-out
// circuit d = (a & b) | ~c, e = ~c. Each start walks abc through 0..7,
// holds every vector SETTLE cycles, samples de for one cycle and keeps a
// saturating mismatch count plus the first failing vector.
module circuit_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [2:0]       abc,
  input  logic [1:0]       de,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state;
  logic [2:0]       r_vec;
  logic [3:0]       r_cnt;
  logic [2:0]       r_abc;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [2:0]       r_fail_vec;
  logic             r_rst_meta;
  logic             r_rst_sync;

  logic             w_rst;
  logic [1:0]       w_exp;
  logic             w_mis;
  logic [ERR_W-1:0] w_err_inc;
  logic [ERR_W-1:0] w_err_next;

  // Reset synchronizer: assertion passes straight through, release is
  // retimed to clk so the FSM never leaves reset on a random phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst = r_rst_sync;

  // Expected circuit response for the vector under test and the mismatch
  // count as it will stand after this sample (saturating).
  always_comb begin
    w_exp      = {(r_vec[2] & r_vec[1]) | ~r_vec[0], ~r_vec[0]};
    w_mis      = (de != w_exp);
    w_err_inc  = (r_err == ERR_MAX) ? r_err : r_err + 1'b1;
    w_err_next = w_mis ? w_err_inc : r_err;
  end

  // Sweep FSM: all outputs are registered here, none depend on de/start
  // combinationally.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= S_IDLE;
      r_vec        <= 3'd0;
      r_cnt        <= 4'd0;
      r_abc        <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_DRIVE;
            r_vec        <= 3'd0;
            r_abc        <= 3'd0;
            r_cnt        <= CNT_LOAD;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
          end
        end
        S_DRIVE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (w_mis) begin
            r_err <= w_err_inc;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_vec;
            end
          end
          if (r_vec == 3'd7) begin
            // Last vector: the sweep ends here; abc stays on 7.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= r_vec + 3'd1;
            r_abc   <= r_vec + 3'd1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_DRIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign abc        = r_abc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_circuit_sweep_checker.sv
// Bench for circuit_sweep_checker: two instances (ERR_W=4 and ERR_W=2,
// both SETTLE=2) run in lockstep from the same start/reset and the same
// circuit model on de, so one sweep exercises both counter widths.
module tb_circuit_sweep_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] de;

  logic [2:0] abc_a,  abc_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a;
  logic [1:0] err_b;
  logic       fv_a, fv_b;
  logic [2:0] fvec_a, fvec_b;

  int total = 0;
  int bad   = 0;

  // Circuit model selector: 0 correct, 1 const 11, 2 e stuck 0,
  // 3 const 01, 4 const 00, 5 correct with random per-vector corruption.
  int         mode = 0;
  logic [1:0] rx [8];

  always #5 clk = ~clk;

  circuit_sweep_checker #(.SETTLE(2), .ERR_W(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abc(abc_a), .de(de),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  circuit_sweep_checker #(.SETTLE(2), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abc(abc_b), .de(de),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  // Reference behaviour of a healthy circuit, straight from the boolean rule.
  function automatic logic [1:0] good_de(input logic [2:0] v);
    bit a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return {((a && b) || !c) ? 1'b1 : 1'b0, (!c) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [1:0] circ(input int m, input logic [2:0] v);
    case (m)
      1:       return 2'b11;
      2:       return {good_de(v)[1], 1'b0};
      3:       return 2'b01;
      4:       return 2'b00;
      5:       return good_de(v) ^ rx[v];
      default: return good_de(v);
    endcase
  endfunction

  always_comb begin
    de = 2'b00;
    case (mode)
      1: de = 2'b11;
      2: de = {good_de(abc_a)[1], 1'b0};
      3: de = 2'b01;
      4: de = 2'b00;
      5: de = good_de(abc_a) ^ rx[abc_a];
      default: de = good_de(abc_a);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pulse start, follow the sweep edge by edge, check abc stepping and
  // that done arrives exactly 24 edges after the accepting edge.
  // restart_at >= 0 re-raises start at that cycle of the sweep.
  task automatic run_sweep(input string tag, input int restart_at);
    int k;
    int abc_bad;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy_rise"}, {30'd0, busy_a, busy_b}, 32'd3);
    chk({tag, "_done_clear"}, {30'd0, done_a, done_b}, 32'd0);
    k = 0;
    abc_bad = 0;
    while (k < 60 && !done_a) begin
      if (k < 24 && (abc_a != 3'(k / 3) || abc_b != abc_a)) abc_bad++;
      start = (k == restart_at);
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    chk({tag, "_abc_steps_bad"}, abc_bad, 0);
    chk({tag, "_sweep_len"}, k, 24);
  endtask

  // Compare both instances against the expected sweep outcome.
  task automatic check_result(input string tag, input int e_err, input bit e_fv, input int e_vec);
    int e_sat;
    e_sat = (e_err > 3) ? 3 : e_err;
    chk({tag, "_err_a"}, err_a, e_err);
    chk({tag, "_err_b"}, err_b, e_sat);
    chk({tag, "_fv"}, {30'd0, fv_a, fv_b}, {30'd0, e_fv, e_fv});
    chk({tag, "_fvec_a"}, fvec_a, e_fv ? e_vec : 0);
    chk({tag, "_fvec_b"}, fvec_b, e_fv ? e_vec : 0);
    chk({tag, "_pass"}, {30'd0, pass_a, pass_b}, (e_err == 0) ? 32'd3 : 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy_a, done_b}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_abc"}, {abc_a, abc_b}, 0);
    chk({tag, "_flags"}, {busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b}, 0);
    chk({tag, "_err"}, {err_a, err_b}, 0);
    chk({tag, "_fvec"}, {fvec_a, fvec_b}, 0);
  endtask

  task automatic release_reset();
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int m;
    int err;
    bit fv;
    int vec;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int e_err, e_vec;
    bit e_fv;

    tbl[0] = '{m: 0, err: 0, fv: 1'b0, vec: 0};
    tbl[1] = '{m: 1, err: 4, fv: 1'b1, vec: 1};
    tbl[2] = '{m: 2, err: 4, fv: 1'b1, vec: 0};
    tbl[3] = '{m: 3, err: 8, fv: 1'b1, vec: 0};
    tbl[4] = '{m: 4, err: 5, fv: 1'b1, vec: 0};
    for (int i = 0; i < 8; i++) rx[i] = 2'b00;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check_reset_state("por");
    release_reset();
    check_reset_state("idle");

    // Table of fixed circuit behaviours
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].m;
      run_sweep($sformatf("tbl%0d", i), -1);
      check_result($sformatf("tbl%0d", i), tbl[i].err, tbl[i].fv, tbl[i].vec);
    end

    // Restart with the correct model clears the previous failure
    mode = 2;
    run_sweep("stuck", -1);
    check_result("stuck", 4, 1'b1, 0);
    mode = 0;
    run_sweep("recover", -1);
    check_result("recover", 0, 1'b0, 0);

    // start while busy at abc=3 is ignored; sweep length unchanged
    mode = 1;
    run_sweep("mid_start", 9);
    check_result("mid_start", 4, 1'b1, 1);

    // start coincident with the last SAMPLE is ignored
    mode = 0;
    run_sweep("last_start", 23);
    check_result("last_start", 0, 1'b0, 0);
    @(posedge clk);
    #1 chk("last_start_stays_done", {30'd0, busy_a, done_a}, 32'd1);

    // Reset during DRIVE of vector 5 with errors already counted
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #1 chk("pre_reset_abc", abc_a, 5);
    chk("pre_reset_err", err_a, 2);
    #2 reset = 1'b1;
    #1 check_reset_state("mid_reset");
    release_reset();
    check_reset_state("mid_reset_idle");
    mode = 0;
    run_sweep("after_reset", -1);
    check_result("after_reset", 0, 1'b0, 0);

    // Random per-vector corruption against the reference model
    mode = 5;
    for (int t = 0; t < 20; t++) begin
      for (int v = 0; v < 8; v++)
        rx[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      e_err = 0;
      e_fv  = 1'b0;
      e_vec = 0;
      for (int v = 0; v < 8; v++) begin
        if (circ(5, 3'(v)) != good_de(3'(v))) begin
          e_err++;
          if (!e_fv) begin
            e_fv  = 1'b1;
            e_vec = v;
          end
        end
      end
      run_sweep($sformatf("rnd%0d", t), -1);
      check_result($sformatf("rnd%0d", t), e_err, e_fv, e_vec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
